irq_ctrl_4: RTL and testbench

Four-source interrupt controller for the risc32i core. Detects rising edges on four interrupt lines, latches them as pending, and filters them through a software-written enable mask. It picks the highest-priority enabled pending source through the existing 4-to-2 one-hot encoder, then runs a request/acknowledge/done handshake with the core's trap logic. It sits between external/peripheral interrupt lines and the control unit, and is the only user of that encoder.

---
 rtl/irq_pkg.sv | 11 +
 rtl/irq_ctrl_4_if.sv | 21 ++
 rtl/irq_ctrl_4_encoder.sv | 15 +
 rtl/irq_ctrl_4.sv | 118 +++++++++++
 tb/tb_irq_ctrl_4.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/irq_pkg.sv
// rtl/irq_pkg.sv - shared types and sizes for the four-source interrupt controller
package irq_pkg;
    localparam int N_SRC = 4;
    localparam int ID_W  = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ASSERT  = 2'd1,
        SERVICE = 2'd2
    } irq_state_e;
endpackage

// File: rtl/irq_ctrl_4_if.sv
// rtl/irq_ctrl_4_if.sv - request/acknowledge/done handshake between controller and core trap logic
interface irq_ctrl_4_if;
    import irq_pkg::*;

    logic            irq_o;
    logic [ID_W-1:0] irq_id;
    logic            irq_ack;
    logic            irq_done;
    logic            busy_o;
    logic            timeout_o;

    modport master (
        output irq_o, irq_id, busy_o, timeout_o,
        input  irq_ack, irq_done
    );

    modport slave (
        input  irq_o, irq_id, busy_o, timeout_o,
        output irq_ack, irq_done
    );
endinterface

// File: rtl/irq_ctrl_4_encoder.sv
// rtl/irq_ctrl_4_encoder.sv - 4-to-2 one-hot encoder; zero input encodes to 0
module Encoder_4 (
    input  logic [3:0] onehot,
    output logic [1:0] id
);
    always_comb begin
        id = 2'd0;
        case (onehot)
            4'b0010: id = 2'd1;
            4'b0100: id = 2'd2;
            4'b1000: id = 2'd3;
            default: id = 2'd0;
        endcase
    end
endmodule

// File: rtl/irq_ctrl_4.sv
// rtl/irq_ctrl_4.sv - edge-latched, masked, fixed-priority interrupt controller with ack/done handshake
module irq_ctrl_4
    import irq_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] irq_src,
    input  logic             mask_we,
    input  logic [N_SRC-1:0] mask_wdata,
    output logic [N_SRC-1:0] mask_o,
    output logic [N_SRC-1:0] pending_o,
    irq_ctrl_4_if.master     bus
);
    localparam logic [7:0] TO_LAST = (TIMEOUT == 0) ? 8'd0 : 8'(TIMEOUT - 1);

    logic [N_SRC-1:0] src_q;
    logic [N_SRC-1:0] pending;
    logic [N_SRC-1:0] mask;
    logic [N_SRC-1:0] rise;
    logic [N_SRC-1:0] clr;
    logic [N_SRC-1:0] cand;
    logic [N_SRC-1:0] gnt;
    logic [ID_W-1:0]  enc_id;
    logic [ID_W-1:0]  id_r;
    logic [7:0]       cnt;
    irq_state_e       state;
    logic             irq_r;
    logic             busy_r;
    logic             to_r;
    logic             ack_take;
    logic             timeout_hit;

    assign ack_take    = (state == ASSERT) && bus.irq_ack;
    assign timeout_hit = (TIMEOUT != 0) && (cnt == TO_LAST);

    assign rise = irq_src & ~src_q;
    assign clr  = ack_take ? (N_SRC'(1) << id_r) : '0;

    // Two's-complement trick isolates the lowest set bit, so gnt is always one-hot or zero.
    assign cand = pending & mask;
    assign gnt  = cand & (~cand + N_SRC'(1));

    Encoder_4 u_enc (
        .onehot (gnt),
        .id     (enc_id)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            src_q   <= '0;
            pending <= '0;
            mask    <= '0;
        end else begin
            src_q   <= irq_src;
            pending <= (pending & ~clr) | rise;
            if (mask_we) begin
                mask <= mask_wdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            id_r   <= '0;
            cnt    <= '0;
            irq_r  <= 1'b0;
            busy_r <= 1'b0;
            to_r   <= 1'b0;
        end else begin
            to_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (cand != '0) begin
                        id_r  <= enc_id;
                        cnt   <= '0;
                        irq_r <= 1'b1;
                        state <= ASSERT;
                    end
                end
                ASSERT: begin
                    // Ack is checked first so it beats a timeout landing on the same edge.
                    if (bus.irq_ack) begin
                        irq_r  <= 1'b0;
                        busy_r <= 1'b1;
                        state  <= SERVICE;
                    end else if (timeout_hit) begin
                        irq_r <= 1'b0;
                        to_r  <= 1'b1;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                SERVICE: begin
                    if (bus.irq_done) begin
                        busy_r <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: begin
                    irq_r  <= 1'b0;
                    busy_r <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign mask_o        = mask;
    assign pending_o     = pending;
    assign bus.irq_o     = irq_r;
    assign bus.irq_id    = id_r;
    assign bus.busy_o    = busy_r;
    assign bus.timeout_o = to_r;
endmodule

// File: tb/tb_irq_ctrl_4.sv
// tb/tb_irq_ctrl_4.sv - scoreboard bench for irq_ctrl_4 against a behavioural model
module tb_irq_ctrl_4;
    localparam int TB_TO = 4;

    typedef struct packed {
        logic [3:0] mask;
        logic [3:0] pend;
        logic       irq;
        logic [1:0] id;
        logic       busy;
        logic       to;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] irq_src = 4'd0;
    logic       mask_we = 1'b0;
    logic [3:0] mask_wdata = 4'd0;
    logic [3:0] mask_o;
    logic [3:0] pending_o;

    irq_ctrl_4_if bus ();

    irq_ctrl_4 #(.TIMEOUT(TB_TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .irq_src    (irq_src),
        .mask_we    (mask_we),
        .mask_wdata (mask_wdata),
        .mask_o     (mask_o),
        .pending_o  (pending_o),
        .bus        (bus.master)
    );

    always #5 clk = ~clk;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Behavioural model: phase 0 = waiting, 1 = requesting, 2 = being served
    int       m_phase = 0;
    int       m_elapsed = 0;
    bit [3:0] m_prev = 0;
    bit [3:0] m_pend = 0;
    bit [3:0] m_mask = 0;
    bit [1:0] m_id = 0;
    bit       m_to = 0;

    task automatic model(input bit r, input bit [3:0] s, input bit we, input bit [3:0] wd,
                         input bit a, input bit d);
        bit [3:0] np;
        int pick;
        exp_t e;
        if (r) begin
            m_phase = 0; m_elapsed = 0; m_prev = 0; m_pend = 0; m_mask = 0; m_id = 0; m_to = 0;
        end else begin
            np = m_pend;
            m_to = 0;
            if (m_phase == 0) begin
                pick = -1;
                for (int i = 0; i < 4; i++)
                    if (pick < 0 && m_pend[i] && m_mask[i]) pick = i;
                if (pick >= 0) begin
                    m_id = 2'(pick);
                    m_elapsed = 0;
                    m_phase = 1;
                end
            end else if (m_phase == 1) begin
                if (a) begin
                    np[m_id] = 1'b0;
                    m_phase = 2;
                end else begin
                    m_elapsed++;
                    if (TB_TO != 0 && m_elapsed == TB_TO) begin
                        m_to = 1;
                        m_phase = 0;
                    end
                end
            end else if (d) begin
                m_phase = 0;
            end
            for (int i = 0; i < 4; i++)
                if (s[i] && !m_prev[i]) np[i] = 1'b1;
            m_prev = s;
            m_pend = np;
            if (we) m_mask = wd;
        end
        e.mask = m_mask;
        e.pend = m_pend;
        e.irq  = (m_phase == 1);
        e.id   = m_id;
        e.busy = (m_phase == 2);
        e.to   = m_to;
        exp_q.push_back(e);
    endtask

    task automatic step(input bit r, input bit [3:0] s, input bit we, input bit [3:0] wd,
                        input bit a, input bit d);
        @(negedge clk);
        rst = r; irq_src = s; mask_we = we; mask_wdata = wd;
        bus.irq_ack = a; bus.irq_done = d;
        model(r, s, we, wd, a, d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 4'd0, 0, 4'd0, 0, 0);
    endtask

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, req);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("mask_o", mask_o, e.mask);
            chk("pending_o", pending_o, e.pend);
            chk("irq_o", {3'b0, bus.irq_o}, {3'b0, e.irq});
            chk("irq_id", {2'b0, bus.irq_id}, {2'b0, e.id});
            chk("busy_o", {3'b0, bus.busy_o}, {3'b0, e.busy});
            chk("timeout_o", {3'b0, bus.timeout_o}, {3'b0, e.to});
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit [3:0] rs;
        bus.irq_ack = 1'b0;
        bus.irq_done = 1'b0;
        step(1, 4'd0, 0, 4'd0, 0, 0);
        step(1, 4'd0, 0, 4'd0, 0, 0);

        // single source 2
        step(0, 4'd0, 1, 4'hF, 0, 0);
        step(0, 4'b0100, 0, 4'd0, 0, 0);
        idle(3);
        step(0, 4'd0, 0, 4'd0, 1, 0);
        idle(1);
        step(0, 4'd0, 0, 4'd0, 0, 1);
        idle(2);

        // simultaneous 1 and 3
        step(0, 4'b1010, 0, 4'd0, 0, 0);
        idle(2);
        step(0, 4'd0, 0, 4'd0, 1, 0);
        step(0, 4'd0, 0, 4'd0, 0, 1);
        idle(2);
        step(0, 4'd0, 0, 4'd0, 1, 0);
        step(0, 4'd0, 0, 4'd0, 0, 1);
        idle(2);

        // masked source 3, then unmasked
        step(0, 4'd0, 1, 4'b0001, 0, 0);
        step(0, 4'b1000, 0, 4'd0, 0, 0);
        idle(3);
        step(0, 4'd0, 1, 4'b1000, 0, 0);
        idle(2);
        step(0, 4'd0, 0, 4'd0, 1, 0);
        step(0, 4'd0, 0, 4'd0, 0, 1);
        idle(2);

        // timeout and re-request, then a late ack
        step(0, 4'd0, 1, 4'hF, 0, 0);
        step(0, 4'b0010, 0, 4'd0, 0, 0);
        idle(12);
        step(0, 4'd0, 0, 4'd0, 1, 0);
        step(0, 4'd0, 0, 4'd0, 0, 1);
        idle(2);

        // re-edge on source 0 during its own service
        step(0, 4'b0001, 0, 4'd0, 0, 0);
        idle(2);
        step(0, 4'd0, 0, 4'd0, 1, 0);
        step(0, 4'b0001, 0, 4'd0, 0, 0);
        idle(2);
        step(0, 4'd0, 0, 4'd0, 0, 1);
        idle(2);
        step(0, 4'd0, 0, 4'd0, 1, 0);
        step(0, 4'd0, 0, 4'd0, 0, 1);
        idle(2);

        // reset mid-request
        step(0, 4'b0100, 0, 4'd0, 0, 0);
        idle(2);
        step(1, 4'd0, 0, 4'd0, 0, 0);
        idle(2);

        // randomized traffic
        rs = 4'd0;
        for (int i = 0; i < 3000; i++) begin
            bit r, we, a, d;
            bit [3:0] wd;
            if ($urandom_range(0, 7) == 0) rs = rs ^ 4'($urandom_range(0, 15));
            r  = ($urandom_range(0, 199) == 0);
            we = ($urandom_range(0, 15) == 0);
            wd = 4'($urandom_range(0, 15));
            a  = ($urandom_range(0, 2) == 0);
            d  = ($urandom_range(0, 3) == 0);
            step(r, rs, we, wd, a, d);
        end
        idle(2);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected entries left unchecked", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
